// File: rtl/iecdrv_sd_arb.sv
// iecdrv_sd_arb: round-robin arbiter that shares one host block-device channel
// among up to four IEC drive units, steering ack and buffer traffic to the
// granted drive. Optional REQ abort timer: `define IECDRV_SD_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module iecdrv_sd_arb #(
  parameter int unsigned  DRIVES  = 2,
  parameter logic [23:0]  TIMEOUT = 24'hFFFFFF,
  localparam int unsigned NDR     = (DRIVES == 0) ? 1 : ((DRIVES > 4) ? 4 : DRIVES),
  localparam int unsigned N       = NDR - 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] drv_lba [NDR],
  input  logic [N:0]  drv_rd,
  input  logic [N:0]  drv_wr,
  output logic [N:0]  drv_ack,
  output logic [N:0]  drv_err,
  output logic [N:0]  drv_buff_wr,
  input  logic [7:0]  drv_buff_din [NDR],
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  g_q, g_d;
  logic [1:0]  p_q, p_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [N:0]  ack_q, ack_d;
  logic [N:0]  g_oh;
  logic        found;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
  logic [N:0]  err_q, err_d;
  logic [23:0] cnt_q, cnt_d;
`endif

  // One-hot view of the current grant, used for ack, error and strobe steering
  always_comb begin
    g_oh = '0;
    for (int unsigned j = 0; j < NDR; j++) begin
      g_oh[j] = (g_q == 2'(j));
    end
  end

  // Next-state logic: rotating scan in IDLE, host handshake in REQ/XFER
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = ack_q;
    found   = 1'b0;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
    err_d   = '0;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Visit drives p, p+1, ... and take the first one asking for service
        for (int unsigned k = 0; k < NDR; k++) begin
          for (int unsigned j = 0; j < NDR; j++) begin
            if (!found && (((32'(p_q) + k) % NDR) == j) && (drv_rd[j] || drv_wr[j])) begin
              found = 1'b1;
              g_d   = 2'(j);
              lba_d = drv_lba[j];
              rd_d  = drv_rd[j];
              wr_d  = ~drv_rd[j];
            end
          end
        end
        if (found) begin
          state_d = REQ;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = g_oh;
          state_d = XFER;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
        end else if (24'(cnt_q + 24'd1) == TIMEOUT) begin
          // Host never answered: withdraw the request and flag the drive
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = g_oh;
          state_d = DONE;
        end else begin
          cnt_d   = 24'(cnt_q + 24'd1);
`endif
        end
      end
      XFER: begin
        if (!sd_ack) begin
          ack_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Move the pointer past the drive just served so others go first
        p_d     = (g_q == 2'(N)) ? 2'd0 : 2'(g_q + 2'd1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
      err_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Zero-latency buffer steering: strobe gated to the grant, data muxed by grant
  always_comb begin
    drv_buff_wr = (state_q == XFER && sd_buff_wr) ? g_oh : '0;
    sd_buff_din = '0;
    for (int unsigned j = 0; j < NDR; j++) begin
      if (g_q == 2'(j)) begin
        sd_buff_din = drv_buff_din[j];
      end
    end
  end

  assign drv_ack = ack_q;
  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
`ifdef IECDRV_SD_ARB_TIMEOUT_EN
  assign drv_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign drv_err = '0;
`endif

endmodule

// File: doc/iecdrv_sd_arb.md
# iecdrv_sd_arb

Host-side responder that serves the per-drive SD block requests of the multi-drive IEC drive cluster over the single `clk_sys` block-device channel. Drive units issue `sd_rd`/`sd_wr` with an LBA. This block grants them one at a time in round-robin order, forwards the request to the host block interface and routes `sd_ack` back to the granted drive. It also steers the shared buffer bus to that drive: write strobes go to the granted drive, read data comes from it. It sits between the drive array and the system block-device port, entirely in the `clk_sys` domain.

## Interface
Parameters:
- `DRIVES`, 2: number of drive request ports. Clamped: NDR = 1..4, N = NDR-1.
- `TIMEOUT`, 24'hFFFFFF: clk_sys cycles allowed in REQ before abort. Used only with the timeout feature.

Ports:
- `clk_sys`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `drv_lba[NDR]`  in  32  per-drive requested LBA.
- `drv_rd`  in  N+1  per-drive read request, level, held until the drive sees its ack.
- `drv_wr`  in  N+1  per-drive write request, same rules as `drv_rd`.
- `drv_ack`  out  N+1  per-drive acknowledge; only the granted bit can be high.
- `drv_err`  out  N+1  per-drive one-cycle timeout-abort pulse.
- `drv_buff_wr`  out  N+1  per-drive gated buffer write strobe.
- `drv_buff_din[NDR]`  in  8  per-drive buffer read data for host writes.
- `sd_lba`  out  32  LBA to host.
- `sd_rd`  out  1  read request to host.
- `sd_wr`  out  1  write request to host.
- `sd_ack`  in  1  host acknowledge; high for the entire block transfer.
- `sd_buff_wr`  in  1  host buffer write strobe.
- `sd_buff_din`  out  8  buffer data to host; comes from the granted drive.

## Operation
- State machine states: IDLE, REQ, XFER, DONE. Registers: grant index `g` (2 bits), round-robin pointer `p`, latched LBA and direction.
- **IDLE**
  - Scans drives p, p+1, …, wrapping modulo NDR. The first drive with `drv_rd|drv_wr` high wins.
  - On a win, the block latches `g`, `drv_lba[g]` and the direction. Read wins if both `drv_rd` and `drv_wr` are high.
  - On the same edge it sets `sd_rd` or `sd_wr` and moves to REQ.
  - With no request pending it stays in IDLE.
- **REQ**
  - Holds `sd_lba` and `sd_rd`/`sd_wr` constant.
  - Ignores the granted drive withdrawing its request; an issued host request is never retracted, except by timeout.
  - When `sd_ack` = 1: clears `sd_rd`/`sd_wr`, sets `drv_ack[g]`=1 and moves to XFER.
- **XFER**
  - `drv_buff_wr[g]` = `sd_buff_wr` (combinational gate); all other bits are 0.
  - `sd_buff_din` = `drv_buff_din[g]` in every state; the mux is combinational on `g`.
  - When `sd_ack` = 0: clears `drv_ack[g]` and moves to DONE.
- **DONE**
  - Sets p = g+1 mod NDR and moves to IDLE after one cycle.
  - A drive that still holds its request is served again only after the other pending drives.
- `sd_ack` high while in IDLE or DONE is ignored.
- Disabled ports (index ≥ NDR) do not exist. `drv_*` arrays are sized N+1.

## Timing
- Reset values: all outputs 0, `sd_lba`=0. Internal state: IDLE, p=0, g=0.
- Reset mid-operation clears all outputs asynchronously; a host transfer in flight is abandoned.
- Request sampled high at edge k → `sd_rd`/`sd_wr` and `sd_lba` valid after edge k.
- `sd_ack` rising sampled at edge m → `drv_ack[g]` high and `sd_rd` low after edge m.
- `sd_ack` falling sampled at edge n → `drv_ack[g]` low after edge n. Earliest next grant is at edge n+2.
- `drv_buff_wr` and `sd_buff_din` have zero latency (combinational).

## Configuration
- `IECDRV_SD_ARB_TIMEOUT_EN` defined:
  - A 24-bit counter clears on entry to REQ and increments each cycle while in REQ.
  - At count == `TIMEOUT`, the block clears `sd_rd`/`sd_wr` and pulses `drv_err[g]` for one cycle. It then moves to DONE, and p advances.
- Macro undefined: no counter; REQ waits indefinitely; `drv_err` is tied to 0.

## Test plan
- **Single read.** NDR=2; drive 0 raises `drv_rd` with lba=0x00000123; host acks 4 cycles later and holds `sd_ack` for 512 cycles of `sd_buff_wr` pulses. Required:
  - `sd_lba`=0x123 and `sd_rd`=1 one cycle after the request.
  - `drv_ack[0]` mirrors the ack window.
  - `drv_buff_wr[1]` stays 0 throughout.
- **Round robin.** NDR=4; drives 0, 2 and 3 request simultaneously from reset. Required: grants in order 0, 2, 3. Drive 0 re-requests immediately after its ack and is served after 3.
- **rd+wr collision.** Drive 1 raises `drv_rd` and `drv_wr` together. Required: `sd_rd`=1, `sd_wr`=0.
- **Write data path.** Drive 1 is granted for a write with `drv_buff_din[1]`=0xA5 and `drv_buff_din[0]`=0x5A. Required: `sd_buff_din`=0xA5 during XFER.
- **Reset during XFER.** Assert `reset` while `drv_ack[0]`=1. Required: all outputs read 0 before the next edge; the first grant after release is drive 0.
- **Timeout (macro defined, `TIMEOUT`=16).** Drive 0 requests and the host never acks. Required:
  - `sd_rd` falls and `drv_err[0]` pulses 16 cycles after REQ entry.
  - A pending drive 1 is granted 2 cycles later.
